// File: rtl/rv32i_lsu_pkg.sv
// rv32i_lsu_pkg: FSM states, LOAD/STORE funct3 encodings (incl. LD/SD/LWU)
// and the access-size lane mask helper for the multicycle LSU.
package rv32i_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUSY,
        LSU_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        unique case (sz)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_lsu_multicycle_align.sv
// lsu_lane_align: byte enables, store replication, load extension, decode.
// LSU_MISALIGN_TRAP_EN enables the misalign flag; otherwise it stays 0.
module lsu_lane_align
    import rv32i_lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int OFF_W  = $clog2(BE_W)
) (
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   byte_ena_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o,
    output logic              illegal_o
);

    logic [1:0]        sz;
    logic [2:0]        lane_m;
    logic [OFF_W-1:0]  off_a;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              sbit;
    int                nbits;

    assign sz     = funct3_i[1:0];
    assign lane_m = 3'((1 << sz) - 1);
    assign off_a  = off_i & ~lane_m[OFF_W-1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o = |(off_i & lane_m[OFF_W-1:0]);
`else
    assign misalign_o = 1'b0;
`endif

    assign byte_ena_o = BE_W'(size_mask(sz)) << off_a;

    always_comb begin
        if (we_i)
            illegal_o = (funct3_i > F3_SD) ||
                        (DATA_W == 32 && funct3_i == F3_SD);
        else
            illegal_o = (funct3_i == 3'b111) ||
                        (DATA_W == 32 &&
                         (funct3_i == F3_LD || funct3_i == F3_LWU));
    end

    // Each lane takes the source byte at its index modulo the access size
    always_comb begin
        wdata_o = '0;
        for (int i = 0; i < BE_W; i++)
            wdata_o[8*i +: 8] = wdata_i[8*(i & int'(lane_m)) +: 8];
    end

    always_comb begin
        nbits = 8 << sz;
        if (nbits > DATA_W)
            nbits = DATA_W;
        shifted = rdata_i >> {off_a, 3'b000};
        keep    = ~({DATA_W{1'b1}} << nbits);
        sbit    = ~funct3_i[2] & shifted[nbits-1];
        rdata_o = (shifted & keep) | (sbit ? ~keep : '0);
    end

endmodule

// File: rtl/rv32i_lsu_multicycle.sv
// rv32i_lsu_multicycle: variable-latency LSU with sub-word lanes and timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module rv32i_lsu_multicycle
    import rv32i_lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wr_ena,
    output logic [DATA_W/8-1:0]   mem_byte_ena,
    output logic [DATA_W-1:0]     mem_wr_data,
    input  logic [DATA_W-1:0]     mem_rd_data
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              we_q, we_d;
    logic              rv_q, rv_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mreq_q, mreq_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              mwe_q, mwe_d;
    logic [BE_W-1:0]   mbe_q, mbe_d;
    logic [DATA_W-1:0] mwd_q, mwd_d;

    logic              idle;
    logic              sel_we;
    logic [2:0]        sel_f3;
    logic [OFF_W-1:0]  sel_off;
    logic [BE_W-1:0]   al_be;
    logic [DATA_W-1:0] al_wd;
    logic [DATA_W-1:0] al_rd;
    logic              al_mis;
    logic              al_ill;

    assign idle      = (state_q == LSU_IDLE);
    assign req_ready = idle;

    // The aligner sees the live request in IDLE and the stored one afterwards
    assign sel_we  = idle ? req_we     : we_q;
    assign sel_f3  = idle ? req_funct3 : f3_q;
    assign sel_off = idle ? req_addr[OFF_W-1:0] : off_q;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .we_i       (sel_we),
        .funct3_i   (sel_f3),
        .off_i      (sel_off),
        .wdata_i    (req_wdata),
        .rdata_i    (mem_rd_data),
        .byte_ena_o (al_be),
        .wdata_o    (al_wd),
        .rdata_o    (al_rd),
        .misalign_o (al_mis),
        .illegal_o  (al_ill)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        we_d    = we_q;
        rv_d    = rv_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mreq_d  = mreq_q;
        maddr_d = maddr_q;
        mwe_d   = mwe_q;
        mbe_d   = mbe_q;
        mwd_d   = mwd_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    f3_d  = req_funct3;
                    off_d = req_addr[OFF_W-1:0];
                    we_d  = req_we;
                    cnt_d = '0;
                    if (al_ill || al_mis) begin
                        state_d = LSU_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = LSU_BUSY;
                        mreq_d  = 1'b1;
                        maddr_d = {req_addr[ADDR_W-1:OFF_W],
                                   {OFF_W{1'b0}}};
                        mwe_d   = req_we;
                        mbe_d   = al_be;
                        mwd_d   = req_we ? al_wd : '0;
                    end
                end
            end
            LSU_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack) begin
                    state_d = LSU_RESP;
                    rv_d    = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : al_rd;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    mbe_d   = '0;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    state_d = LSU_RESP;
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    mbe_d   = '0;
                end
            end
            LSU_RESP: begin
                // Error-at-accept paths arrive with rv_q=0 and pulse a cycle later
                if (rv_q) begin
                    state_d = LSU_IDLE;
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else begin
                    rv_d = 1'b1;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            mreq_q  <= 1'b0;
            maddr_q <= '0;
            mwe_q   <= 1'b0;
            mbe_q   <= '0;
            mwd_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            we_q    <= we_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            mreq_q  <= mreq_d;
            maddr_q <= maddr_d;
            mwe_q   <= mwe_d;
            mbe_q   <= mbe_d;
            mwd_q   <= mwd_d;
        end
    end

    assign resp_valid   = rv_q;
    assign resp_err     = err_q;
    assign resp_rdata   = rdata_q;
    assign mem_req      = mreq_q;
    assign mem_addr     = maddr_q;
    assign mem_wr_ena   = mwe_q;
    assign mem_byte_ena = mbe_q;
    assign mem_wr_data  = mwd_q;

endmodule
